// File: rtl/async_fifo_lvl.sv
// -----------------------------------------------------------------------------
// async_fifo_lvl
// Dual-clock FIFO between the MII receive/transmit clock domains and the
// byte-stream logic. The pointers cross domains in Gray code. Full and empty
// are registered. Each side also reports a conservative fill count,
// almost-full/almost-empty levels and sticky overflow/underflow flags.
//
// One external active-low reset (rrst_n) serves both domains. It asserts
// asynchronously and is released into each domain through a SYNC_STAGES-deep
// synchroniser.
//
// Parameters
//   DSIZE       data width
//   ASIZE       address bits, depth = 2**ASIZE (ASIZE >= 2)
//   SYNC_STAGES synchroniser depth for pointers and reset (2 or 3)
//   AFULL_TH    walmost_full when wcount >= AFULL_TH
//   AEMPTY_TH   ralmost_empty when rcount <= AEMPTY_TH
//   RD_REG      0 = show-ahead read, 1 = registered read with 1-cycle latency
//
// Ports
//   wclk, rclk            write / read clocks
//   rrst_n                asynchronous active-low reset for both domains
//   winc, wdata           write request and data
//   wfull, walmost_full   write-side level flags (registered)
//   wcount                write-side fill level, 0..2**ASIZE
//   woverflow             sticky: a write was attempted while full
//   rinc                  read request
//   rdata, rvalid         read data and its qualifier
//   rempty, ralmost_empty read-side level flags (registered)
//   rcount                read-side fill level
//   runderflow            sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module async_fifo_lvl #(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 12,
    parameter int AEMPTY_TH   = 2,
    parameter int RD_REG      = 0
) (
    input  logic             wclk,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wcount,
    output logic             woverflow,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rcount,
    output logic             runderflow
);

    localparam int             PW        = ASIZE + 1;
    localparam int             DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_C   = PW'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C  = PW'(AEMPTY_TH);

    // Binary to reflected Gray code.
    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return b ^ {1'b0, b[ASIZE:1]};
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Reset synchronisers: assert immediately, release after SYNC_STAGES edges
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] wrst_sync_q;
    logic [SYNC_STAGES-1:0] rrst_sync_q;
    logic                   wrst_n_s;
    logic                   rrst_n_s;

    // Write-domain reset release synchroniser.
    always_ff @(posedge wclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wrst_sync_q <= '0;
        end else begin
            wrst_sync_q <= {wrst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Read-domain reset release synchroniser.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rrst_sync_q <= '0;
        end else begin
            rrst_sync_q <= {rrst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign wrst_n_s = wrst_sync_q[SYNC_STAGES-1];
    assign rrst_n_s = rrst_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DSIZE-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [ASIZE:0]                   wbin_q, wbin_d;
    logic [ASIZE:0]                   wgray_q, wgray_d;
    logic                             wfull_q, wfull_d;
    logic                             walmost_full_q, walmost_full_d;
    logic [ASIZE:0]                   wcount_q, wcount_d;
    logic                             woverflow_q, woverflow_d;
    logic                             wr_en_s;
    logic [SYNC_STAGES-1:0][ASIZE:0]  wq_rgray_q;
    logic [ASIZE:0]                   rgray_sync_s;
    logic [ASIZE:0]                   rbin_sync_s;

    assign rgray_sync_s = wq_rgray_q[SYNC_STAGES-1];
    assign rbin_sync_s  = gray2bin(rgray_sync_s);

    // Write-side next state: pointer advance, full test, level and overflow.
    always_comb begin
        wr_en_s        = winc & ~wfull_q;
        wbin_d         = wbin_q + {{ASIZE{1'b0}}, wr_en_s};
        wgray_d        = bin2gray(wbin_d);
        // Full when the next write pointer has lapped the read pointer once:
        // Gray codes differ only in the two MSBs.
        wfull_d        = (wgray_d == {~rgray_sync_s[ASIZE:ASIZE-1],
                                      rgray_sync_s[ASIZE-2:0]});
        // The stale read pointer makes this an over-estimate of occupancy.
        wcount_d       = wbin_d - rbin_sync_s;
        walmost_full_d = (wcount_d >= AFULL_C);
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    // Write-side state registers; wfull held high while in reset.
    always_ff @(posedge wclk or negedge wrst_n_s) begin
        if (!wrst_n_s) begin
            wbin_q         <= '0;
            wgray_q        <= '0;
            wfull_q        <= 1'b1;
            walmost_full_q <= 1'b0;
            wcount_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wcount_q       <= wcount_d;
            woverflow_q    <= woverflow_d;
        end
    end

    // Read Gray pointer synchroniser into the write domain.
    always_ff @(posedge wclk or negedge wrst_n_s) begin
        if (!wrst_n_s) begin
            wq_rgray_q <= '0;
        end else begin
            wq_rgray_q <= {wq_rgray_q[SYNC_STAGES-2:0], rgray_q};
        end
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge wclk) begin
        if (wr_en_s) begin
            mem_q[wbin_q[ASIZE-1:0]] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic [ASIZE:0]                   rbin_q, rbin_d;
    logic [ASIZE:0]                   rgray_q, rgray_d;
    logic                             rempty_q, rempty_d;
    logic                             ralmost_empty_q, ralmost_empty_d;
    logic [ASIZE:0]                   rcount_q, rcount_d;
    logic                             runderflow_q, runderflow_d;
    logic                             rd_en_s;
    logic [SYNC_STAGES-1:0][ASIZE:0]  rq_wgray_q;
    logic [ASIZE:0]                   wgray_sync_s;
    logic [ASIZE:0]                   wbin_sync_s;
    logic [ASIZE-1:0]                 raddr_s;
    logic [DSIZE-1:0]                 rdata_s;
    logic                             rvalid_s;

    assign wgray_sync_s = rq_wgray_q[SYNC_STAGES-1];
    assign wbin_sync_s  = gray2bin(wgray_sync_s);
    assign raddr_s      = rbin_q[ASIZE-1:0];

    // Read-side next state: pointer advance, empty test, level and underflow.
    always_comb begin
        rd_en_s         = rinc & ~rempty_q;
        rbin_d          = rbin_q + {{ASIZE{1'b0}}, rd_en_s};
        rgray_d         = bin2gray(rbin_d);
        rempty_d        = (rgray_d == wgray_sync_s);
        // The stale write pointer makes this an under-estimate of occupancy.
        rcount_d        = wbin_sync_s - rbin_d;
        ralmost_empty_d = (rcount_d <= AEMPTY_C);
        runderflow_d    = runderflow_q | (rinc & rempty_q);
    end

    // Read-side state registers.
    always_ff @(posedge rclk or negedge rrst_n_s) begin
        if (!rrst_n_s) begin
            rbin_q          <= '0;
            rgray_q         <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rcount_q        <= '0;
            runderflow_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rcount_q        <= rcount_d;
            runderflow_q    <= runderflow_d;
        end
    end

    // Write Gray pointer synchroniser into the read domain.
    always_ff @(posedge rclk or negedge rrst_n_s) begin
        if (!rrst_n_s) begin
            rq_wgray_q <= '0;
        end else begin
            rq_wgray_q <= {rq_wgray_q[SYNC_STAGES-2:0], wgray_q};
        end
    end

    generate
        if (RD_REG == 0) begin : g_show_ahead
            // Show-ahead: the head word is presented directly, zero while empty.
            always_comb begin
                if (rempty_q) begin
                    rdata_s = '0;
                end else begin
                    rdata_s = mem_q[raddr_s];
                end
            end
            assign rvalid_s = ~rempty_q;
        end else begin : g_registered
            logic [DSIZE-1:0] rdata_q;
            logic             rvalid_q;

            // Registered read: capture the head word on an accepted read.
            always_ff @(posedge rclk or negedge rrst_n_s) begin
                if (!rrst_n_s) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_en_s;
                    if (rd_en_s) begin
                        rdata_q <= mem_q[raddr_s];
                    end
                end
            end
            assign rdata_s  = rdata_q;
            assign rvalid_s = rvalid_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign wcount        = wcount_q;
    assign woverflow     = woverflow_q;
    assign rdata         = rdata_s;
    assign rvalid        = rvalid_s;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rcount        = rcount_q;
    assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_async_fifo_lvl.sv
// -----------------------------------------------------------------------------
// Directed/random bench for async_fifo_lvl. Two instances share all inputs:
// dut_a uses show-ahead reads (RD_REG=0) and dut_b registered reads (RD_REG=1).
// Both domains are driven and sampled on the falling edge of their own clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_async_fifo_lvl;

    logic       wclk = 1'b0;
    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       wfull_a, walmost_full_a, woverflow_a, rvalid_a, rempty_a, ralmost_empty_a, runderflow_a;
    logic [4:0] wcount_a, rcount_a;
    logic [7:0] rdata_a;
    logic       wfull_b, walmost_full_b, woverflow_b, rvalid_b, rempty_b, ralmost_empty_b, runderflow_b;
    logic [4:0] wcount_b, rcount_b;
    logic [7:0] rdata_b;

    realtime w_half = 5.0;
    realtime r_half = 13.5;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb_q[$];

    // All outputs packed in port order; the value during/after reset is fixed.
    logic [24:0] vec_a, vec_b;
    localparam logic [24:0] RST_VEC = {1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 8'd0, 1'b0, 1'b0};
    assign vec_a = {wfull_a, walmost_full_a, wcount_a, woverflow_a, rempty_a, ralmost_empty_a,
                    rcount_a, rdata_a, rvalid_a, runderflow_a};
    assign vec_b = {wfull_b, walmost_full_b, wcount_b, woverflow_b, rempty_b, ralmost_empty_b,
                    rcount_b, rdata_b, rvalid_b, runderflow_b};

    always #(w_half) wclk = ~wclk;
    always #(r_half) rclk = ~rclk;

    async_fifo_lvl #(.DSIZE(8), .ASIZE(4), .SYNC_STAGES(2), .AFULL_TH(12), .AEMPTY_TH(2), .RD_REG(0)) dut_a (
        .wclk(wclk), .rclk(rclk), .rrst_n(rrst_n), .winc(winc), .wdata(wdata),
        .wfull(wfull_a), .walmost_full(walmost_full_a), .wcount(wcount_a), .woverflow(woverflow_a),
        .rinc(rinc), .rdata(rdata_a), .rvalid(rvalid_a), .rempty(rempty_a),
        .ralmost_empty(ralmost_empty_a), .rcount(rcount_a), .runderflow(runderflow_a));

    async_fifo_lvl #(.DSIZE(8), .ASIZE(4), .SYNC_STAGES(2), .AFULL_TH(12), .AEMPTY_TH(2), .RD_REG(1)) dut_b (
        .wclk(wclk), .rclk(rclk), .rrst_n(rrst_n), .winc(winc), .wdata(wdata),
        .wfull(wfull_b), .walmost_full(walmost_full_b), .wcount(wcount_b), .woverflow(woverflow_b),
        .rinc(rinc), .rdata(rdata_b), .rvalid(rvalid_b), .rempty(rempty_b),
        .ralmost_empty(ralmost_empty_b), .rcount(rcount_b), .runderflow(runderflow_b));

    task automatic do_reset();
        @(negedge wclk);
        winc   = 1'b0;
        rinc   = 1'b0;
        rrst_n = 1'b0;
        repeat (5) @(negedge wclk);
        rrst_n = 1'b1;
        repeat (4) @(negedge wclk);
        repeat (5) @(negedge rclk);
    endtask

    task automatic wr_word(input logic [7:0] d);
        @(negedge wclk);
        winc  = 1'b1;
        wdata = d;
        @(negedge wclk);
        winc  = 1'b0;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        repeat (5) @(negedge wclk);
        n_cmp++; if (vec_a !== RST_VEC) begin n_bad++; $display("FAIL reset_vals_a: got %h expected %h", vec_a, RST_VEC); end
        n_cmp++; if (vec_b !== RST_VEC) begin n_bad++; $display("FAIL reset_vals_b: got %h expected %h", vec_b, RST_VEC); end
        rrst_n = 1'b1;
        @(negedge wclk);
        n_cmp++; if (wfull_a !== 1'b1) begin n_bad++; $display("FAIL wfull_edge1: got %b expected 1", wfull_a); end
        repeat (2) @(negedge wclk);
        n_cmp++; if (wfull_a !== 1'b0) begin n_bad++; $display("FAIL wfull_edge3_a: got %b expected 0", wfull_a); end
        n_cmp++; if (wfull_b !== 1'b0) begin n_bad++; $display("FAIL wfull_edge3_b: got %b expected 0", wfull_b); end
        repeat (5) @(negedge rclk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_word(8'(i));
            n_cmp++; if (wcount_a !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_wcount[%0d]: got %0d expected %0d", i, wcount_a, i + 1); end
            n_cmp++; if (walmost_full_a !== ((i + 1) >= 12)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, walmost_full_a, (i + 1) >= 12); end
            n_cmp++; if (wfull_a !== ((i + 1) == 16)) begin n_bad++; $display("FAIL fill_wfull[%0d]: got %b expected %b", i, wfull_a, (i + 1) == 16); end
        end
        wr_word(8'hFF);
        n_cmp++; if (woverflow_a !== 1'b1) begin n_bad++; $display("FAIL overflow_set: got %b expected 1", woverflow_a); end
        n_cmp++; if (wcount_a !== 5'd16) begin n_bad++; $display("FAIL overflow_wcount: got %0d expected 16", wcount_a); end
        n_cmp++; if (woverflow_b !== 1'b1) begin n_bad++; $display("FAIL overflow_set_b: got %b expected 1", woverflow_b); end
        repeat (8) @(negedge rclk);
        n_cmp++; if (rcount_a !== 5'd16) begin n_bad++; $display("FAIL fill_rcount: got %0d expected 16", rcount_a); end
        n_cmp++; if (ralmost_empty_a !== 1'b0) begin n_bad++; $display("FAIL fill_aempty: got %b expected 0", ralmost_empty_a); end
        n_cmp++; if (rvalid_b !== 1'b0) begin n_bad++; $display("FAIL fill_rvalid_b: got %b expected 0", rvalid_b); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rdata_a !== 8'(i)) begin n_bad++; $display("FAIL drain_show[%0d]: got %h expected %h", i, rdata_a, 8'(i)); end
            n_cmp++; if (rvalid_a !== 1'b1) begin n_bad++; $display("FAIL drain_rvalid_a[%0d]: got %b expected 1", i, rvalid_a); end
            rinc = 1'b1;
            @(negedge rclk);
            rinc = 1'b0;
            n_cmp++; if (rcount_a !== 5'(15 - i)) begin n_bad++; $display("FAIL drain_rcount[%0d]: got %0d expected %0d", i, rcount_a, 15 - i); end
            n_cmp++; if (ralmost_empty_a !== ((15 - i) <= 2)) begin n_bad++; $display("FAIL drain_aempty[%0d]: got %b expected %b", i, ralmost_empty_a, (15 - i) <= 2); end
            n_cmp++; if (rempty_a !== (i == 15)) begin n_bad++; $display("FAIL drain_rempty[%0d]: got %b expected %b", i, rempty_a, i == 15); end
            n_cmp++; if ({rvalid_b, rdata_b} !== {1'b1, 8'(i)}) begin n_bad++; $display("FAIL drain_reg_b[%0d]: got %b/%h expected 1/%h", i, rvalid_b, rdata_b, 8'(i)); end
        end
        n_cmp++; if ({rvalid_a, rdata_a} !== 9'h000) begin n_bad++; $display("FAIL empty_rdata_a: got %b/%h expected 0/00", rvalid_a, rdata_a); end
        rinc = 1'b1;
        @(negedge rclk);
        rinc = 1'b0;
        n_cmp++; if (runderflow_a !== 1'b1) begin n_bad++; $display("FAIL underflow_a: got %b expected 1", runderflow_a); end
        n_cmp++; if (runderflow_b !== 1'b1) begin n_bad++; $display("FAIL underflow_b: got %b expected 1", runderflow_b); end
        n_cmp++; if (rvalid_b !== 1'b0) begin n_bad++; $display("FAIL underflow_rvalid_b: got %b expected 0", rvalid_b); end
        n_cmp++; if (rcount_a !== 5'd0) begin n_bad++; $display("FAIL underflow_rcount: got %0d expected 0", rcount_a); end
        repeat (6) @(negedge wclk);
        n_cmp++; if ({wfull_a, walmost_full_a, wcount_a, woverflow_a} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin
            n_bad++; $display("FAIL drained_wside: got %b/%b/%0d/%b expected 0/0/0/1", wfull_a, walmost_full_a, wcount_a, woverflow_a);
        end
    endtask

    task automatic test_regread();
        int k;
        wr_word(8'hA5);
        k = 0;
        while (rempty_a && k < 10) begin
            @(posedge rclk);
            @(negedge rclk);
            k++;
        end
        n_cmp++; if (!(k <= 4 && !rempty_a)) begin n_bad++; $display("FAIL w2r_latency: got %0d rclk edges expected <= 4", k); end
        n_cmp++; if (rdata_a !== 8'hA5) begin n_bad++; $display("FAIL regread_show_a: got %h expected a5", rdata_a); end
        n_cmp++; if (rvalid_b !== 1'b0) begin n_bad++; $display("FAIL regread_pre: got %b expected 0", rvalid_b); end
        rinc = 1'b1;
        @(negedge rclk);
        rinc = 1'b0;
        n_cmp++; if ({rvalid_b, rdata_b} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL regread_hit: got %b/%h expected 1/a5", rvalid_b, rdata_b); end
        @(negedge rclk);
        n_cmp++; if ({rvalid_b, rdata_b} !== {1'b0, 8'hA5}) begin n_bad++; $display("FAIL regread_hold: got %b/%h expected 0/a5", rvalid_b, rdata_b); end
        n_cmp++; if (rempty_a !== 1'b1) begin n_bad++; $display("FAIL regread_empty_a: got %b expected 1", rempty_a); end
    endtask

    task automatic test_random(input realtime wh, input realtime rh, input int n);
        int wn, rn, wc, rc;
        logic pend;
        logic [7:0] pv, ev;
        w_half = wh;
        r_half = rh;
        do_reset();
        sb_q.delete();
        wn = 0; rn = 0; wc = 0; rc = 0; pend = 1'b0; pv = 8'h00; ev = 8'h00;
        fork
            begin
                while (wn < n && wc < 40000) begin
                    @(negedge wclk);
                    wc++;
                    winc = 1'b0;
                    if (!wfull_a && $urandom_range(0, 1) == 1) begin
                        wdata = 8'($urandom);
                        winc  = 1'b1;
                        sb_q.push_back(wdata);
                        wn++;
                    end
                end
                @(negedge wclk);
                winc = 1'b0;
            end
            begin
                while ((rn < n || pend) && rc < 40000) begin
                    @(negedge rclk);
                    rc++;
                    rinc = 1'b0;
                    if (pend) begin
                        n_cmp++; if ({rvalid_b, rdata_b} !== {1'b1, pv}) begin n_bad++; $display("FAIL rand_reg_b[%0d]: got %b/%h expected 1/%h", rn, rvalid_b, rdata_b, pv); end
                        pend = 1'b0;
                    end
                    if (rvalid_a && $urandom_range(0, 1) == 1) begin
                        n_cmp++;
                        if (sb_q.size() == 0) begin
                            n_bad++; $display("FAIL rand_spurious: got rvalid with no word written expected empty");
                        end else begin
                            ev = sb_q.pop_front();
                            if (rdata_a !== ev) begin n_bad++; $display("FAIL rand_data_a[%0d]: got %h expected %h", rn, rdata_a, ev); end
                            pv   = ev;
                            pend = 1'b1;
                            rinc = 1'b1;
                            rn++;
                        end
                    end
                end
                rinc = 1'b0;
            end
        join
        n_cmp++; if (wn != n) begin n_bad++; $display("FAIL rand_wr_budget: got %0d expected %0d", wn, n); end
        n_cmp++; if (rn != n) begin n_bad++; $display("FAIL rand_rd_budget: got %0d expected %0d", rn, n); end
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL rand_leftover: got %0d expected 0", sb_q.size()); end
        n_cmp++; if ({woverflow_a, runderflow_a, woverflow_b, runderflow_b} !== 4'b0000) begin
            n_bad++; $display("FAIL rand_flags: got %b%b%b%b expected 0000", woverflow_a, runderflow_a, woverflow_b, runderflow_b);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        w_half = 5.0;
        r_half = 13.5;
        do_reset();
        @(negedge rclk);
        rinc = 1'b1;
        @(negedge rclk);
        rinc = 1'b0;
        n_cmp++; if (runderflow_a !== 1'b1) begin n_bad++; $display("FAIL mid_pre_underflow: got %b expected 1", runderflow_a); end
        for (int i = 0; i < 7; i++) wr_word(8'(8'h30 + i));
        repeat (8) @(negedge rclk);
        n_cmp++; if (rcount_a !== 5'd7) begin n_bad++; $display("FAIL mid_pre_rcount: got %0d expected 7", rcount_a); end
        @(negedge wclk);
        #2;
        rrst_n = 1'b0;
        #1;
        n_cmp++; if (vec_a !== RST_VEC) begin n_bad++; $display("FAIL mid_reset_a: got %h expected %h", vec_a, RST_VEC); end
        n_cmp++; if (vec_b !== RST_VEC) begin n_bad++; $display("FAIL mid_reset_b: got %h expected %h", vec_b, RST_VEC); end
        repeat (3) @(negedge wclk);
        rrst_n = 1'b1;
        repeat (4) @(negedge wclk);
        n_cmp++; if (wfull_a !== 1'b0) begin n_bad++; $display("FAIL mid_release_wfull: got %b expected 0", wfull_a); end
        repeat (4) @(negedge rclk);
        wr_word(8'h5A);
        k = 0;
        while (rempty_a && k < 10) begin
            @(negedge rclk);
            k++;
        end
        n_cmp++; if ({rempty_a, rdata_a} !== {1'b0, 8'h5A}) begin n_bad++; $display("FAIL mid_first_word: got %b/%h expected 0/5a", rempty_a, rdata_a); end
        n_cmp++; if (rcount_a !== 5'd1) begin n_bad++; $display("FAIL mid_rcount: got %0d expected 1", rcount_a); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_regread();
        test_random(5.0, 13.5, 1000);
        test_random(13.5, 3.0, 1000);
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
